// File: rtl/term_vram_ctrl.sv
// term_vram_ctrl: terminal byte interpreter that owns the write port of the character VRAM.
//   in_data/in_valid/in_ready : byte stream in (transfer on in_valid && in_ready)
//   vram_addr/vram_data/vram_we: registered write port, addr = {1'b0, phys_row, col}
//   scroll_row                 : physical row shown as screen row 0
//   cur_col/cur_row            : screen-relative cursor
//   busy                       : clear sequence in progress (= !in_ready)
module term_vram_ctrl #(
  parameter int COLS  = 80,
  parameter int ROWS  = 30,
  parameter int LF_CR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        vram_we,
  output logic [4:0]  scroll_row,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy
);
  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [5:0] ROWS6 = 6'(ROWS);
  state_t state, state_n;
  logic [6:0] col_n, clr_col, clr_col_n;
  logic [4:0] row_n, scroll_n, clr_row, clr_row_n, phys, nxt_scroll;
  logic [5:0] sum;
  logic fin, fin_n, pend_v, pend_v_n, we_n, take, nl, wrap;
  logic [11:0] pend_addr, pend_addr_n, addr_n;
  logic [7:0] pend_data, pend_data_n, data_n;
  assign sum = {1'b0, cur_row} + {1'b0, scroll_row};
  assign phys = sum >= ROWS6 ? 5'(sum - ROWS6) : sum[4:0];
  assign wrap = cur_row == LAST_ROW;
  assign nxt_scroll = scroll_row == LAST_ROW ? 5'd0 : scroll_row + 5'd1;
  assign take = in_valid && in_ready;
  assign busy = !in_ready;
  // A decoded byte's write is staged in pend_* and issued one cycle later;
  // a staged write always wins the port, so a line clear started by a
  // wrapping character waits one cycle behind that character's own write.
  always_comb begin
    state_n = state;
    col_n = cur_col;
    row_n = cur_row;
    scroll_n = scroll_row;
    clr_col_n = clr_col;
    clr_row_n = clr_row;
    fin_n = fin;
    pend_v_n = 1'b0;
    pend_addr_n = pend_addr;
    pend_data_n = pend_data;
    we_n = pend_v;
    addr_n = pend_addr;
    data_n = pend_data;
    nl = 1'b0;
    case (state)
      IDLE: if (take) begin
        if (in_data >= 8'h20 && in_data <= 8'h7E) begin
          pend_v_n = 1'b1;
          pend_addr_n = {phys, cur_col};
          pend_data_n = in_data;
          col_n = cur_col == LAST_COL ? 7'd0 : cur_col + 7'd1;
          nl = cur_col == LAST_COL;
        end else if (in_data == 8'h0D) begin
          col_n = 7'd0;
        end else if (in_data == 8'h0A) begin
          nl = 1'b1;
          col_n = LF_CR != 0 ? 7'd0 : cur_col;
        end else if (in_data == 8'h08 && cur_col != 7'd0) begin
          col_n = cur_col - 7'd1;
          pend_v_n = 1'b1;
          pend_addr_n = {phys, col_n};
          pend_data_n = 8'h20;
        end else if (in_data == 8'h0C) begin
          scroll_n = 5'd0;
          col_n = 7'd0;
          row_n = 5'd0;
          clr_row_n = 5'd0;
          clr_col_n = 7'd0;
          state_n = CLR_ALL;
        end
        if (nl) begin
          row_n = wrap ? cur_row : cur_row + 5'd1;
          scroll_n = wrap ? nxt_scroll : scroll_row;
          // Old top row becomes the new bottom row: blank it instead of copying.
          if (wrap) begin
            state_n = CLR_LINE;
            clr_row_n = scroll_row;
            clr_col_n = 7'd0;
          end
        end
      end
      default: if (fin) begin
        state_n = IDLE;
        fin_n = 1'b0;
      end else if (!pend_v) begin
        we_n = 1'b1;
        addr_n = {clr_row, clr_col};
        data_n = 8'h20;
        if (clr_col == LAST_COL) begin
          clr_col_n = 7'd0;
          fin_n = state == CLR_LINE || clr_row == LAST_ROW;
          clr_row_n = fin_n ? 5'd0 : clr_row + 5'd1;
        end else begin
          clr_col_n = clr_col + 7'd1;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR_ALL;
      cur_col <= 7'd0;
      cur_row <= 5'd0;
      scroll_row <= 5'd0;
      clr_col <= 7'd0;
      clr_row <= 5'd0;
      fin <= 1'b0;
      pend_v <= 1'b0;
      pend_addr <= 12'd0;
      pend_data <= 8'h20;
      vram_we <= 1'b0;
      vram_addr <= 13'd0;
      vram_data <= 8'h20;
      in_ready <= 1'b0;
    end else begin
      state <= state_n;
      cur_col <= col_n;
      cur_row <= row_n;
      scroll_row <= scroll_n;
      clr_col <= clr_col_n;
      clr_row <= clr_row_n;
      fin <= fin_n;
      pend_v <= pend_v_n;
      pend_addr <= pend_addr_n;
      pend_data <= pend_data_n;
      vram_we <= we_n;
      vram_addr <= {1'b0, addr_n};
      vram_data <= data_n;
      in_ready <= state_n == IDLE;
    end
  end
endmodule

// File: tb/tb_term_vram_ctrl.sv
// tb_term_vram_ctrl: directed self-checking bench for term_vram_ctrl at default parameters.
module tb_term_vram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready, vram_we, busy;
  logic [12:0] vram_addr;
  logic [7:0] vram_data;
  logic [4:0] scroll_row, cur_row;
  logic [6:0] cur_col;
  int errors = 0;
  int checks = 0;
  logic [12:0] wa[$];
  logic [7:0] wd[$];
  term_vram_ctrl dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_we(vram_we),
    .scroll_row(scroll_row), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (vram_we) begin
      wa.push_back(vram_addr);
      wd.push_back(vram_data);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic send(input logic [7:0] b);
    in_data = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask
  task automatic run_clear_all(output int writes, output int bad, output int ready_at);
    writes = 0;
    bad = 0;
    ready_at = -1;
    for (int k = 0; k < 2403; k++) begin
      @(negedge clk);
      if (vram_we) begin
        if (vram_addr !== {1'b0, 5'(writes / 80), 7'(writes % 80)} || vram_data !== 8'h20) bad++;
        writes++;
      end
      if (in_ready && ready_at < 0) begin
        ready_at = k;
        break;
      end
    end
  endtask
  task automatic test_reset();
    int w, b, r;
    repeat (3) @(negedge clk);
    checks++;
    if ({vram_we, vram_addr, vram_data, in_ready, busy} !== {1'b0, 13'd0, 8'h20, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h rdy=%b busy=%b expected 0 0000 20 0 1", vram_we, vram_addr, vram_data, in_ready, busy);
    end
    checks++;
    if ({scroll_row, cur_col, cur_row} !== 17'd0) begin
      errors++;
      $display("FAIL reset_cursor: got scroll=%0d col=%0d row=%0d expected 0 0 0", scroll_row, cur_col, cur_row);
    end
    rst = 1'b0;
    run_clear_all(w, b, r);
    checks++;
    if (w !== 2400) begin errors++; $display("FAIL init_write_count: got %0d expected 2400", w); end
    checks++;
    if (b !== 0) begin errors++; $display("FAIL init_addr_data: got %0d bad writes expected 0", b); end
    checks++;
    if (r !== 2400) begin errors++; $display("FAIL init_ready_edge: got %0d expected 2400", r); end
  endtask
  task automatic test_char();
    clear_log();
    send(8'h41);
    checks++;
    if (cur_col !== 7'd1) begin errors++; $display("FAIL char_col: got %0d expected 1", cur_col); end
    @(negedge clk);
    checks++;
    if (wa.size() !== 1) begin errors++; $display("FAIL char_count: got %0d expected 1", wa.size()); end
    if (wa.size() > 0) begin
      checks++;
      if ({wa[0], wd[0]} !== {13'h000, 8'h41}) begin
        errors++;
        $display("FAIL char_write: got addr=%h data=%h expected 000 41", wa[0], wd[0]);
      end
    end
  endtask
  task automatic test_wrap();
    send(8'h0D);
    clear_log();
    for (int i = 0; i < 79; i++) send(8'h78);
    send(8'h79);
    checks++;
    if ({cur_col, cur_row, in_ready} !== {7'd0, 5'd1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_cursor: got col=%0d row=%0d rdy=%b expected 0 1 1", cur_col, cur_row, in_ready);
    end
    @(negedge clk);
    checks++;
    if (wa.size() !== 80) begin errors++; $display("FAIL wrap_count: got %0d expected 80", wa.size()); end
    if (wa.size() == 80) begin
      checks++;
      if ({wa[79], wd[79]} !== {13'h04F, 8'h79}) begin
        errors++;
        $display("FAIL wrap_last: got addr=%h data=%h expected 04f 79", wa[79], wd[79]);
      end
    end
    clear_log();
    send(8'h7A);
    @(negedge clk);
    checks++;
    if (wa.size() !== 1 || wa[0] !== 13'h080 || wd[0] !== 8'h7A) begin
      errors++;
      $display("FAIL wrap_next: got n=%0d addr=%h expected n=1 addr 080 data 7a", wa.size(), wa.size() > 0 ? wa[0] : 13'h1FFF);
    end
  endtask
  task automatic test_bs();
    send(8'h0D);
    clear_log();
    send(8'h08);
    @(negedge clk);
    checks++;
    if (wa.size() !== 0 || cur_col !== 7'd0) begin
      errors++;
      $display("FAIL bs_col0: got writes=%0d col=%0d expected 0 0", wa.size(), cur_col);
    end
    send(8'h61);
    send(8'h62);
    send(8'h08);
    @(negedge clk);
    checks++;
    if (wa.size() !== 3 || cur_col !== 7'd1) begin
      errors++;
      $display("FAIL bs_count: got writes=%0d col=%0d expected 3 1", wa.size(), cur_col);
    end
    if (wa.size() == 3) begin
      checks++;
      if ({wa[2], wd[2]} !== {13'h081, 8'h20}) begin
        errors++;
        $display("FAIL bs_write: got addr=%h data=%h expected 081 20", wa[2], wd[2]);
      end
    end
    clear_log();
    send(8'h9B);
    @(negedge clk);
    checks++;
    if (wa.size() !== 0 || cur_col !== 7'd1 || cur_row !== 5'd1) begin
      errors++;
      $display("FAIL ignored_byte: got writes=%0d col=%0d row=%0d expected 0 1 1", wa.size(), cur_col, cur_row);
    end
  endtask
  task automatic test_scroll_lf();
    int bad = 0;
    for (int i = 0; i < 28; i++) send(8'h0A);
    checks++;
    if ({cur_row, cur_col, scroll_row} !== {5'd29, 7'd0, 5'd0}) begin
      errors++;
      $display("FAIL lf_to_bottom: got row=%0d col=%0d scroll=%0d expected 29 0 0", cur_row, cur_col, scroll_row);
    end
    send(8'h0A);
    checks++;
    if ({in_ready, busy, scroll_row, cur_row, cur_col} !== {1'b0, 1'b1, 5'd1, 5'd29, 7'd0}) begin
      errors++;
      $display("FAIL lf_scroll_state: got rdy=%b busy=%b scroll=%0d row=%0d col=%0d expected 0 1 1 29 0", in_ready, busy, scroll_row, cur_row, cur_col);
    end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!vram_we || vram_addr !== 13'(k) || vram_data !== 8'h20 || in_ready) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL lf_clear_line: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    checks++;
    if ({in_ready, vram_we} !== 2'b10) begin
      errors++;
      $display("FAIL lf_ready_back: got rdy=%b we=%b expected 1 0", in_ready, vram_we);
    end
    clear_log();
    send(8'h51);
    @(negedge clk);
    checks++;
    if (wa.size() !== 1 || wa[0] !== 13'h000 || wd[0] !== 8'h51) begin
      errors++;
      $display("FAIL scroll_q: got n=%0d addr=%h expected n=1 addr 000 data 51", wa.size(), wa.size() > 0 ? wa[0] : 13'h1FFF);
    end
  endtask
  task automatic test_scroll_char();
    int bad = 0;
    send(8'h0D);
    for (int i = 0; i < 79; i++) send(8'h70);
    send(8'h65);
    checks++;
    if ({in_ready, scroll_row, cur_row, cur_col} !== {1'b0, 5'd2, 5'd29, 7'd0}) begin
      errors++;
      $display("FAIL chr_scroll_state: got rdy=%b scroll=%0d row=%0d col=%0d expected 0 2 29 0", in_ready, scroll_row, cur_row, cur_col);
    end
    @(negedge clk);
    checks++;
    if ({vram_we, vram_addr, vram_data} !== {1'b1, 13'h04F, 8'h65}) begin
      errors++;
      $display("FAIL chr_scroll_own: got we=%b addr=%h data=%h expected 1 04f 65", vram_we, vram_addr, vram_data);
    end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!vram_we || vram_addr !== 13'h080 + 13'(k) || vram_data !== 8'h20 || in_ready) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL chr_clear_line: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    checks++;
    if ({in_ready, vram_we} !== 2'b10) begin
      errors++;
      $display("FAIL chr_ready_back: got rdy=%b we=%b expected 1 0", in_ready, vram_we);
    end
  endtask
  task automatic test_ff();
    int w, b, r;
    send(8'h0C);
    checks++;
    if ({in_ready, scroll_row, cur_row, cur_col} !== 18'd0) begin
      errors++;
      $display("FAIL ff_state: got rdy=%b scroll=%0d row=%0d col=%0d expected 0 0 0 0", in_ready, scroll_row, cur_row, cur_col);
    end
    run_clear_all(w, b, r);
    checks++;
    if (w !== 2400 || b !== 0 || r !== 2400) begin
      errors++;
      $display("FAIL ff_clear: got writes=%0d bad=%0d ready_at=%0d expected 2400 0 2400", w, b, r);
    end
  endtask
  task automatic test_mid_reset();
    int n = 0;
    int w, b, r;
    for (int i = 0; i < 30; i++) send(8'h0A);
    for (int k = 0; k < 200 && n < 40; k++) begin
      @(negedge clk);
      if (vram_we) n++;
    end
    checks++;
    if (n !== 40 || scroll_row !== 5'd1) begin
      errors++;
      $display("FAIL midrst_reach: got writes=%0d scroll=%0d expected 40 1", n, scroll_row);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({vram_we, in_ready, busy, scroll_row, cur_row, cur_col} !== {1'b0, 1'b0, 1'b1, 17'd0}) begin
      errors++;
      $display("FAIL midrst_abort: got we=%b rdy=%b busy=%b scroll=%0d row=%0d col=%0d expected 0 0 1 0 0 0", vram_we, in_ready, busy, scroll_row, cur_row, cur_col);
    end
    rst = 1'b0;
    run_clear_all(w, b, r);
    checks++;
    if (w !== 2400 || b !== 0 || r !== 2400) begin
      errors++;
      $display("FAIL midrst_clear: got writes=%0d bad=%0d ready_at=%0d expected 2400 0 2400", w, b, r);
    end
    checks++;
    if ({scroll_row, cur_row, cur_col} !== 17'd0) begin
      errors++;
      $display("FAIL midrst_cursor: got scroll=%0d row=%0d col=%0d expected 0 0 0", scroll_row, cur_row, cur_col);
    end
  endtask
  initial begin
    test_reset();
    test_char();
    test_wrap();
    test_bs();
    test_scroll_lf();
    test_scroll_char();
    test_ff();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
